// File: rtl/spi_master_ctrl.sv
// Purpose: SPI master, DATA_W-bit full-duplex, all CPOL/CPHA modes, MSB/LSB-first, CS setup/hold/gap.
// Latency: accept at T; cs low from T+1; done_o at T+1+(2*DATA_W+2)*CLK_DIV; ready_o CLK_DIV later.
// Backpressure: start_i is taken only while ready_o=1; requests while busy are dropped, not queued.
//
// Ports:
//   clk_i, rst_i (sync, active-low)       clock and reset
//   start_i, ready_o, done_o              system handshake; done_o pulses when data_out_bo updates
//   cpol_i, cpha_i, lsb_first_i           mode, captured at accept
//   data_in_bi, data_out_bo               TX word (captured at accept), RX word of last transfer
//   spi_miso_i, spi_mosi_o, spi_sclk_o,   SPI pins; spi_cs_o is active-low
//   spi_cs_o
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DATA_W-1:0] data_in_bi,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_out_bo,
  input  logic              spi_miso_i,
  output logic              spi_mosi_o,
  output logic              spi_sclk_o,
  output logic              spi_cs_o
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_GAP} state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [EDGE_W-1:0]   r_edge_cnt;
  logic                r_ready;
  logic                r_done;
  logic [DATA_W-1:0]   r_dout;
  logic                r_mosi;
  logic                r_sclk;
  logic                r_cs;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_lsb;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic lsb,
                                                 input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  logic              w_div_end;
  logic [EDGE_W-1:0] w_edge_num;
  logic              w_leading;
  logic              w_sample;
  logic              w_drive;
  logic              w_edge_evt;

  assign w_div_end  = (r_div_cnt == DIV_LAST);
  // Number of the SCLK edge about to be registered (1-based): odd = leading, even = trailing.
  assign w_edge_num = r_edge_cnt + EDGE_W'(1);
  assign w_leading  = w_edge_num[0];
  assign w_sample   = w_leading ^ r_cpha;
  // CPHA=0 already put the first bit out at accept, so its final trailing edge has nothing to shift.
  assign w_drive    = ~w_sample & (w_edge_num != LAST_EDGE);
  // Edge 1 closes LEAD; XFER then keeps one extra half-period after the last edge before TRAIL.
  assign w_edge_evt = w_div_end &&
                      ((r_state == S_LEAD) || (r_state == S_XFER && r_edge_cnt != LAST_EDGE));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_dout     <= '0;
      r_mosi     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs       <= 1'b1;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_div_cnt <= w_div_end ? '0 : r_div_cnt + DIV_W'(1);
      end
      if (w_edge_evt) begin
        r_sclk     <= ~r_sclk;
        r_edge_cnt <= w_edge_num;
        if (w_sample) begin
          r_rx <= rx_shift(r_rx, r_lsb, spi_miso_i);
        end
        if (w_drive) begin
          r_mosi <= first_bit(r_tx, r_lsb);
          r_tx   <= tx_shift(r_tx, r_lsb);
        end
      end
      case (r_state)
        S_IDLE: begin
          r_cs       <= 1'b1;
          r_mosi     <= 1'b0;
          r_sclk     <= cpol_i;
          r_ready    <= 1'b1;
          r_div_cnt  <= '0;
          r_edge_cnt <= '0;
          if (start_i) begin
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_lsb   <= lsb_first_i;
            r_cs    <= 1'b0;
            r_ready <= 1'b0;
            r_rx    <= '0;
            r_state <= S_LEAD;
            // CPHA=0 presents the first bit during LEAD; the tx register then holds the rest.
            if (cpha_i) begin
              r_mosi <= 1'b0;
              r_tx   <= data_in_bi;
            end else begin
              r_mosi <= first_bit(data_in_bi, lsb_first_i);
              r_tx   <= tx_shift(data_in_bi, lsb_first_i);
            end
          end
        end
        S_LEAD: begin
          if (w_div_end) r_state <= S_XFER;
        end
        S_XFER: begin
          if (w_div_end && r_edge_cnt == LAST_EDGE) r_state <= S_TRAIL;
        end
        S_TRAIL: begin
          if (w_div_end) begin
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
            r_dout  <= r_rx;
            r_done  <= 1'b1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_div_end) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign done_o      = r_done;
  assign data_out_bo = r_dout;
  assign spi_mosi_o  = r_mosi;
  assign spi_sclk_o  = r_sclk;
  assign spi_cs_o    = r_cs;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Purpose: self-checking bench for spi_master_ctrl (CLK_DIV=2 and CLK_DIV=1 instances).
// Latency: expected RX/timing pushed at issue, checked by monitors when done_o pulses.
// Backpressure: stimulus waits for ready_o with bounded loops; expiry counts as a failure.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  // instance 0: DATA_W=8, CLK_DIV=2
  logic start0, cpol0, cpha0, lsb0, rdy0, done0, miso0, mosi0, sclk0, cs0;
  logic [7:0] din0, dout0;
  // instance 1: DATA_W=8, CLK_DIV=1, miso looped to mosi
  logic start1, cpol1, cpha1, lsb1, rdy1, done1, miso1, mosi1, sclk1, cs1;
  logic [7:0] din1, dout1;

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2)) u0 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start0), .cpol_i(cpol0), .cpha_i(cpha0),
    .lsb_first_i(lsb0), .data_in_bi(din0), .ready_o(rdy0), .done_o(done0),
    .data_out_bo(dout0), .spi_miso_i(miso0), .spi_mosi_o(mosi0), .spi_sclk_o(sclk0),
    .spi_cs_o(cs0)
  );

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start1), .cpol_i(cpol1), .cpha_i(cpha1),
    .lsb_first_i(lsb1), .data_in_bi(din1), .ready_o(rdy1), .done_o(done1),
    .data_out_bo(dout1), .spi_miso_i(miso1), .spi_mosi_o(mosi1), .spi_sclk_o(sclk1),
    .spi_cs_o(cs1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // ---------------- SPI slave model for instance 0 ----------------
  logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, s_loop = 1'b1;
  logic [7:0] s_word = 8'h00, s_rx = 8'h00;
  logic       s_miso = 1'b0;
  logic       s_prev_cs = 1'b1, s_prev_sclk = 1'b0;
  int         s_bit = 0;

  assign miso0 = s_loop ? mosi0 : s_miso;
  assign miso1 = mosi1;

  always @(sclk0, cs0) begin
    if (cs0 !== s_prev_cs) begin
      s_prev_cs = cs0;
      if (cs0 === 1'b0) begin
        s_bit  = 0;
        s_rx   = 8'h00;
        s_miso = 1'b0;
        if (!s_cpha) begin
          s_miso = s_lsb ? s_word[0] : s_word[7];
          s_bit  = 1;
        end
      end
    end else if (cs0 === 1'b0 && sclk0 !== s_prev_sclk) begin
      if ((sclk0 != s_cpol) == !s_cpha) begin
        s_rx = s_lsb ? {mosi0, s_rx[7:1]} : {s_rx[6:0], mosi0};
      end else if (s_bit < 8) begin
        s_miso = s_lsb ? s_word[s_bit] : s_word[7 - s_bit];
        s_bit++;
      end
    end
    s_prev_sclk = sclk0;
  end

  // ---------------- scoreboard + monitor, instance 0 ----------------
  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] srx;
    logic       cpol;
  } exp_t;
  exp_t q0[$];
  logic [7:0] q1[$];

  logic m_prev_cs = 1'b1, m_prev_sclk = 1'b0, m_prev_mosi = 1'b0;
  int   fall0 = 0, edges0 = 0, viol0 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (m_prev_cs === 1'b1 && cs0 === 1'b0) begin
      fall0  = cyc;
      edges0 = 0;
      viol0  = 0;
    end else if (m_prev_cs === 1'b0 && cs0 === 1'b0) begin
      if (sclk0 !== m_prev_sclk) edges0++;
      // mosi may only move on the drive edge of the active mode
      if (mosi0 !== m_prev_mosi &&
          !(sclk0 !== m_prev_sclk && ((sclk0 != s_cpol) == s_cpha))) viol0++;
    end
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u0_unexpected_done: got done with rx 0x%0h, required no done", dout0);
      end else begin
        e = q0.pop_front();
        chk("u0_rx_word", dout0, e.rx);
        chk("u0_slave_rx_word", s_rx, e.srx);
        chk("u0_sclk_edges", edges0, 16);
        chk("u0_mosi_edge_violations", viol0, 0);
        chk("u0_done_latency", cyc - fall0, 36);
        chk("u0_sclk_idle_at_done", sclk0, e.cpol);
        chk("u0_cs_high_at_done", cs0, 1);
      end
    end
    m_prev_cs   = cs0;
    m_prev_sclk = sclk0;
    m_prev_mosi = mosi0;
  end

  // ---------------- monitor, instance 1 ----------------
  logic n_prev_cs = 1'b1;
  int   fall1 = 0;

  always @(negedge clk) begin
    logic [7:0] e1;
    if (n_prev_cs === 1'b1 && cs1 === 1'b0) fall1 = cyc;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u1_unexpected_done: got done with rx 0x%0h, required no done", dout1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_rx_word", dout1, e1);
        chk("u1_done_latency", cyc - fall1, 18);
      end
    end
    n_prev_cs = cs1;
  end

  // ---------------- stimulus ----------------
  task automatic xfer0(input logic cpol, input logic cpha, input logic lsb, input logic loop,
                       input logic [7:0] tx, input logic [7:0] sw, input bit disturb);
    exp_t e;
    bit   ok;
    @(negedge clk);
    s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; s_loop = loop; s_word = sw;
    cpol0 = cpol; cpha0 = cpha; lsb0 = lsb; din0 = tx;
    repeat (2) @(negedge clk);
    chk("u0_sclk_idle_before", sclk0, cpol);
    e.rx = loop ? tx : sw;
    e.srx = tx;
    e.cpol = cpol;
    q0.push_back(e);
    start0 = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdy0 === 1'b0) begin ok = 1; break; end
    end
    start0 = 1'b0;
    if (!ok) tmo("u0_accept");
    if (disturb) begin
      repeat (4) @(negedge clk);
      start0 = 1'b1;
      din0 = 8'hFF;
      @(negedge clk);
      start0 = 1'b0;
      cpol0 = ~cpol;
      repeat (10) @(negedge clk);
      cpol0 = cpol;
    end
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy0 === 1'b1) begin ok = 1; break; end
    end
    if (!ok) tmo("u0_ready_return");
    chk("u0_ready_latency", cyc - fall0, 38);
    chk("u0_sclk_idle_after", sclk0, cpol);
  endtask

  initial begin
    bit ok;
    int cs_hi, rdy_hi;
    rst_n = 1'b0;
    start0 = 0; cpol0 = 0; cpha0 = 0; lsb0 = 0; din0 = 8'h00;
    start1 = 0; cpol1 = 0; cpha1 = 0; lsb1 = 0; din1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy0, 1);
    chk("rst_done", done0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_sclk", sclk0, 0);
    chk("rst_cs", cs0, 1);
    chk("rst_u1_ready", rdy1, 1);
    chk("rst_u1_cs", cs1, 1);
    rst_n = 1'b1;

    // mode 0, MSB-first, loopback
    xfer0(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0);
    // mode 3, LSB-first, slave returns 0x3C
    xfer0(1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 8'h3C, 1'b0);
    // mode 1 and mode 2, MSB-first
    xfer0(1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h96, 1'b0);
    xfer0(1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h69, 1'b0);
    // restart request and cpol change mid-transfer are ignored
    xfer0(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    chk("u0_no_extra_transfer_cs", cs0, 1);

    // reset mid-transfer: abort, no done, RX cleared
    s_cpol = 0; s_cpha = 0; s_lsb = 0; s_loop = 1;
    cpol0 = 0; cpha0 = 0; lsb0 = 0; din0 = 8'h77;
    start0 = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdy0 === 1'b0) begin ok = 1; break; end
    end
    start0 = 1'b0;
    if (!ok) tmo("u0_accept_before_reset");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_cs", cs0, 1);
    chk("abort_sclk", sclk0, 0);
    chk("abort_ready", rdy0, 1);
    chk("abort_dout", dout0, 0);
    chk("abort_done", done0, 0);
    repeat (40) @(negedge clk);

    // CLK_DIV=1 back-to-back with start held high
    q1.push_back(8'h12);
    q1.push_back(8'h34);
    din1 = 8'h12;
    start1 = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cs1 === 1'b0) begin ok = 1; break; end
    end
    if (!ok) tmo("u1_first_accept");
    din1 = 8'h34;
    cs_hi = 0;
    rdy_hi = 0;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy1 === 1'b1) rdy_hi++;
      if (cs1 === 1'b1) cs_hi++;
      else if (cs_hi > 0) begin ok = 1; break; end
    end
    start1 = 1'b0;
    if (!ok) tmo("u1_second_accept");
    chk("u1_ready_high_cycles", rdy_hi, 1);
    chk("u1_cs_gap_cycles", cs_hi, 2);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy1 === 1'b1) begin ok = 1; break; end
    end
    if (!ok) tmo("u1_ready_return");

    repeat (10) @(negedge clk);
    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
